// File: rtl/data_cache.sv
// Two-way set-associative, write-through, write-allocate data cache with its own
// backing main memory. Lookup is combinational, so misses are served from memory without stalling.
module data_cache #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int set_bits   = 8,
  parameter int mem_bits   = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            we,
  input  logic [2:0]            funct3,
  input  logic [addr_width-1:0] daddr,
  input  logic [data_width-1:0] wd_data,
  output logic                  cache_hit,
  output logic [data_width-1:0] rd_data
);

  localparam int sets  = 1 << set_bits;
  localparam int tag_w = addr_width - set_bits - 2;
  localparam int words = 1 << (mem_bits - 2);

  logic [data_width-1:0] mem   [words];
  logic [tag_w-1:0]      tag0  [sets];
  logic [tag_w-1:0]      tag1  [sets];
  logic [data_width-1:0] data0 [sets];
  logic [data_width-1:0] data1 [sets];
  logic [sets-1:0]       valid0;
  logic [sets-1:0]       valid1;
  logic [sets-1:0]       lru;

  logic [set_bits-1:0]   idx;
  logic [tag_w-1:0]      tag;
  logic [mem_bits-3:0]   maddr;
  logic                  hit0;
  logic                  hit1;
  logic                  way;
  logic [data_width-1:0] mem_word;
  logic [data_width-1:0] line_new;
  logic [data_width-1:0] mem_new;
  logic                  unused_bits;

  function automatic logic [data_width-1:0] merge_lanes(
    input logic [data_width-1:0] base,
    input logic [data_width-1:0] wd,
    input logic [3:0]            lanes
  );
    logic [data_width-1:0] r;
    r = base;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  assign idx   = daddr[set_bits+1:2];
  assign tag   = daddr[addr_width-1:set_bits+2];
  assign maddr = daddr[mem_bits-1:2];

  // Access size and byte offset are irrelevant: lanes are fully described by we.
  assign unused_bits = ^{funct3, daddr[1:0]};

  assign hit0      = valid0[idx] && (tag0[idx] == tag);
  assign hit1      = valid1[idx] && (tag1[idx] == tag);
  assign cache_hit = hit0 | hit1;
  assign mem_word  = mem[maddr];

  always_comb begin
    rd_data = mem_word;
    if (hit0)      rd_data = data0[idx];
    else if (hit1) rd_data = data1[idx];
  end

  // Way 0 takes priority on a (never expected) double match; misses use the LRU way.
  assign way = hit0 ? 1'b0 : (hit1 ? 1'b1 : lru[idx]);

  // Cache and memory stay identical, so the current word is a valid merge base for both.
  assign line_new = merge_lanes(rd_data, wd_data, we);
  assign mem_new  = merge_lanes(mem_word, wd_data, we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      if (we != 4'b0000) mem[maddr] <= mem_new;
      if (way) begin
        valid1[idx] <= 1'b1;
        tag1[idx]   <= tag;
        data1[idx]  <= line_new;
      end else begin
        valid0[idx] <= 1'b1;
        tag0[idx]   <= tag;
        data0[idx]  <= line_new;
      end
      lru[idx] <= ~way;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus pushes expectations from an LRU/flat-memory
// reference model; a negedge monitor pops and compares the combinational outputs.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  we = 4'b0000;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] daddr = 32'h0;
  logic [31:0] wd_data = 32'h0;
  logic        cache_hit;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;

  bit          exp_hit_q  [$];
  logic [31:0] exp_data_q [$];
  string       exp_name_q [$];

  // Reference model: flat word memory plus a most-recent-first list of tags per set.
  logic [31:0] mmem [int];
  logic [21:0] recent [256][$];

  always #5 clk = ~clk;

  data_cache dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .funct3    (funct3),
    .daddr     (daddr),
    .wd_data   (wd_data),
    .cache_hit (cache_hit),
    .rd_data   (rd_data)
  );

  function automatic logic [31:0] mem_rd(input int w);
    return mmem.exists(w) ? mmem[w] : 32'h0;
  endfunction

  task automatic push_exp(input bit h, input logic [31:0] d, input string nm);
    exp_hit_q.push_back(h);
    exp_data_q.push_back(d);
    exp_name_q.push_back(nm);
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        input string nm);
    int          s;
    int          wi;
    logic [21:0] t;
    bit          h;
    logic [31:0] word;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    daddr   = a;
    we      = w;
    wd_data = d;
    funct3  = 3'($urandom_range(0, 7));
    s  = int'(a[9:2]);
    wi = int'(a[16:2]);
    t  = a[31:10];
    h  = 1'b0;
    foreach (recent[s][k]) if (recent[s][k] == t) h = 1'b1;
    word = mem_rd(wi);
    push_exp(h, word, nm);
    if (w != 4'b0000) begin
      for (int i = 0; i < 4; i++) if (w[i]) word[8*i +: 8] = d[8*i +: 8];
      mmem[wi] = word;
    end
    for (int k = recent[s].size() - 1; k >= 0; k--) if (recent[s][k] == t) recent[s].delete(k);
    recent[s].push_front(t);
    if (recent[s].size() > 2) void'(recent[s].pop_back());
  endtask

  // Holds rst across the next edge while attempting a store that must be suppressed.
  task automatic reset_pulse(input logic [31:0] a);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    daddr   = a;
    we      = 4'hF;
    wd_data = $urandom;
    #1;
    push_exp(1'b0, mem_rd(int'(a[16:2])), "in_reset");
    for (int s = 0; s < 256; s++) recent[s].delete();
  endtask

  always @(negedge clk) begin
    if (exp_hit_q.size() > 0) begin
      bit          eh;
      logic [31:0] ed;
      string       nm;
      eh = exp_hit_q.pop_front();
      ed = exp_data_q.pop_front();
      nm = exp_name_q.pop_front();
      checks++;
      if (cache_hit !== eh) begin
        failures++;
        $display("FAIL %s hit addr=%h got=%b want=%b", nm, daddr, cache_hit, eh);
      end
      checks++;
      if (rd_data !== ed) begin
        failures++;
        $display("FAIL %s data addr=%h got=%h want=%h", nm, daddr, rd_data, ed);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned t;
    int unsigned ix;
    int unsigned off;
    logic [31:0] a;
    logic [3:0]  w;
    repeat (3) @(posedge clk);

    access(32'h100, 4'h0, 32'h0, "cold_read");
    access(32'h100, 4'h0, 32'h0, "warm_read");
    access(32'h200, 4'hF, 32'hDEADBEEF, "word_store");
    access(32'h200, 4'h0, 32'h0, "word_load");
    access(32'h202, 4'h4, 32'h00AA0000, "byte_store");
    access(32'h200, 4'h0, 32'h0, "byte_load");
    access(32'h000, 4'h0, 32'h0, "conf_a");
    access(32'h400, 4'h0, 32'h0, "conf_b");
    access(32'h800, 4'h0, 32'h0, "conf_c");
    access(32'h400, 4'h0, 32'h0, "conf_b_hit");
    access(32'h000, 4'h0, 32'h0, "conf_a_miss");
    access(32'h000, 4'hF, 32'h12345678, "wt_store");
    access(32'h400, 4'h0, 32'h0, "wt_evict1");
    access(32'h800, 4'h0, 32'h0, "wt_evict2");
    access(32'h000, 4'h0, 32'h0, "wt_reload");
    access(32'h200, 4'h0, 32'h0, "pre_reset");
    reset_pulse(32'h200);
    access(32'h200, 4'h0, 32'h0, "post_reset_a");
    access(32'h000, 4'h0, 32'h0, "post_reset_b");
    access(32'h200, 4'h0, 32'h0, "post_reset_rehit");

    for (int n = 0; n < 400; n++) begin
      t   = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) t = $urandom_range(0, 127);
      ix  = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) ix = $urandom_range(0, 255);
      off = $urandom_range(0, 3);
      a   = (t << 10) | (ix << 2) | off;
      w   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if (n == 200) reset_pulse(a);
      access(a, w, $urandom, "random");
    end

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_hit_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_hit_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
